// File: rtl/shift_arbiter.sv
// Two-port round-robin front end for a single shared combinational shifter.
// Each request is latched, driven to the shifter for one cycle, and held as a response.
module shift_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_data,
  input  logic [SHW-1:0]   req0_shamt,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_data,
  input  logic [SHW-1:0]   req1_shamt,
  input  logic [1:0]       req1_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_data,
  output logic             rsp0_err,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_data,
  output logic             rsp1_err,
  output logic             sh_en,
  output logic [WIDTH-1:0] sh_indata,
  output logic [SHW-1:0]   sh_shift,
  output logic [1:0]       sh_op,
  input  logic [WIDTH-1:0] sh_outdata,
  output logic             busy,
  output logic [15:0]      op_count
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic             port_q, port_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SHW-1:0]   shamt_q, shamt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;
  logic [15:0]      count_q, count_d;

  logic             grant0, grant1, win1, reserved;
  logic             rsp0_v, rsp1_v;
  logic             sh_en_c;
  logic [WIDTH-1:0] sh_indata_c;
  logic [SHW-1:0]   sh_shift_c;
  logic [1:0]       sh_op_c;

  assign reserved = (op_q == 2'b11);

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    port_d      = port_q;
    data_d      = data_q;
    shamt_d     = shamt_q;
    op_d        = op_q;
    result_d    = result_q;
    err_d       = err_q;
    count_d     = count_q;
    grant0      = 1'b0;
    grant1      = 1'b0;
    win1        = 1'b0;
    rsp0_v      = 1'b0;
    rsp1_v      = 1'b0;
    sh_en_c     = 1'b0;
    sh_indata_c = '0;
    sh_shift_c  = '0;
    sh_op_c     = 2'b00;

    unique case (state_q)
      StIdle: begin
        if (req0_valid || req1_valid) begin
          // Priority bit only matters under contention.
          win1    = (req0_valid && req1_valid) ? prio_q : req1_valid;
          grant0  = ~win1;
          grant1  = win1;
          port_d  = win1;
          data_d  = win1 ? req1_data : req0_data;
          shamt_d = win1 ? req1_shamt : req0_shamt;
          op_d    = win1 ? req1_op : req0_op;
          state_d = StIssue;
        end
      end
      StIssue: begin
        sh_en_c     = 1'b1;
        sh_indata_c = data_q;
        sh_shift_c  = reserved ? '0 : shamt_q;
        sh_op_c     = reserved ? 2'b00 : op_q;
        result_d    = reserved ? data_q : sh_outdata;
        err_d       = reserved;
        state_d     = StResp;
      end
      StResp: begin
        rsp0_v = ~port_q;
        rsp1_v = port_q;
        if (port_q ? rsp1_ready : rsp0_ready) begin
          state_d = StIdle;
          count_d = count_q + 16'd1;
          prio_d  = ~port_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      prio_q   <= 1'b0;
      port_q   <= 1'b0;
      data_q   <= '0;
      shamt_q  <= '0;
      op_q     <= 2'b00;
      result_q <= '0;
      err_q    <= 1'b0;
      count_q  <= 16'd0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      port_q   <= port_d;
      data_q   <= data_d;
      shamt_q  <= shamt_d;
      op_q     <= op_d;
      result_q <= result_d;
      err_q    <= err_d;
      count_q  <= count_d;
    end
  end

  // Outputs are forced low while reset is held, even mid-transaction.
  assign req0_ready = grant0 & ~rst;
  assign req1_ready = grant1 & ~rst;
  assign rsp0_valid = rsp0_v & ~rst;
  assign rsp1_valid = rsp1_v & ~rst;
  assign rsp0_data  = rsp0_valid ? result_q : '0;
  assign rsp1_data  = rsp1_valid ? result_q : '0;
  assign rsp0_err   = rsp0_valid & err_q;
  assign rsp1_err   = rsp1_valid & err_q;
  assign sh_en      = sh_en_c & ~rst;
  assign sh_indata  = rst ? '0 : sh_indata_c;
  assign sh_shift   = rst ? '0 : sh_shift_c;
  assign sh_op      = rst ? 2'b00 : sh_op_c;
  assign busy       = (state_q != StIdle) & ~rst;
  assign op_count   = rst ? 16'd0 : count_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: vector table plus contention, backpressure,
// reset-in-flight and counter-wrap sequences. The shared shifter is modelled here.
module tb_shift_arbiter;
  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [WIDTH-1:0] req0_data, req1_data;
  logic [SHW-1:0]   req0_shamt, req1_shamt;
  logic [1:0]       req0_op, req1_op;
  logic             rsp0_valid, rsp0_ready, rsp0_err, rsp1_valid, rsp1_ready, rsp1_err;
  logic [WIDTH-1:0] rsp0_data, rsp1_data;
  logic             sh_en, busy;
  logic [WIDTH-1:0] sh_indata, sh_outdata;
  logic [SHW-1:0]   sh_shift;
  logic [1:0]       sh_op;
  logic [15:0]      op_count;

  shift_arbiter #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req0_shamt(req0_shamt), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .req1_shamt(req1_shamt), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .rsp1_err(rsp1_err),
    .sh_en(sh_en), .sh_indata(sh_indata), .sh_shift(sh_shift), .sh_op(sh_op),
    .sh_outdata(sh_outdata), .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Shared shifter; op 11 returns garbage so any leak of the reserved op is visible.
  always_comb begin
    case (sh_op)
      2'b00:   sh_outdata = sh_indata >> sh_shift;
      2'b01:   sh_outdata = sh_indata << sh_shift;
      2'b10:   sh_outdata = 32'($signed(sh_indata) >>> sh_shift);
      default: sh_outdata = ~sh_indata;
    endcase
  end

  typedef struct {
    logic        port;
    logic [31:0] data;
    logic [4:0]  shamt;
    logic [1:0]  op;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t        vecs[9];
  vec_t        v;
  int          n_pass  = 0;
  int          n_total = 0;
  logic [15:0] exp_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic set_req(input logic p, input logic vld, input logic [31:0] d,
                         input logic [4:0] s, input logic [1:0] o);
    if (!p) begin
      req0_valid = vld; req0_data = d; req0_shamt = s; req0_op = o;
    end else begin
      req1_valid = vld; req1_data = d; req1_shamt = s; req1_op = o;
    end
  endtask

  function automatic logic rdy(input logic p);
    return p ? req1_ready : req0_ready;
  endfunction
  function automatic logic rvld(input logic p);
    return p ? rsp1_valid : rsp0_valid;
  endfunction
  function automatic logic [31:0] rdat(input logic p);
    return p ? rsp1_data : rsp0_data;
  endfunction
  function automatic logic rerr(input logic p);
    return p ? rsp1_err : rsp0_err;
  endfunction

  // Drops both requests and waits (bounded) for the block to return to idle.
  task automatic wait_idle();
    logic done;
    done = 1'b0;
    set_req(1'b0, 1'b0, 32'h0, 5'd0, 2'b00);
    set_req(1'b1, 1'b0, 32'h0, 5'd0, 2'b00);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    check("drain_to_idle", done, 1);
  endtask

  // One transaction from idle with the response port ready.
  task automatic run_vec(input vec_t t);
    @(negedge clk);
    set_req(t.port, 1'b1, t.data, t.shamt, t.op);
    #1;
    check("vec_req_ready", rdy(t.port), 1);
    check("vec_other_ready", rdy(~t.port), 0);
    @(negedge clk);
    set_req(t.port, 1'b0, 32'h0, 5'd0, 2'b00);
    check("issue_sh_en", sh_en, 1);
    check("issue_sh_indata", sh_indata, t.data);
    check("issue_sh_shift", sh_shift, (t.op == 2'b11) ? 5'd0 : t.shamt);
    check("issue_sh_op", sh_op, (t.op == 2'b11) ? 2'b00 : t.op);
    check("issue_rsp_not_yet", rvld(t.port), 0);
    check("issue_ready_low", rdy(t.port), 0);
    @(negedge clk);
    check("resp_valid", rvld(t.port), 1);
    check("resp_data", rdat(t.port), t.exp_data);
    check("resp_err", rerr(t.port), t.exp_err);
    check("resp_other_valid", rvld(~t.port), 0);
    check("resp_other_data", rdat(~t.port), 0);
    check("resp_sh_en_low", sh_en, 0);
    @(negedge clk);
    exp_count = exp_count + 16'd1;
    check("post_busy", busy, 0);
    check("post_op_count", op_count, exp_count);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 32'h8000_0000, 5'd4,  2'b10, 32'hF800_0000, 1'b0};
    vecs[1] = '{1'b0, 32'h8000_0000, 5'd4,  2'b00, 32'h0800_0000, 1'b0};
    vecs[2] = '{1'b1, 32'h0000_0001, 5'd31, 2'b01, 32'h8000_0000, 1'b0};
    vecs[3] = '{1'b1, 32'h1234_5678, 5'd7,  2'b11, 32'h1234_5678, 1'b1};
    vecs[4] = '{1'b0, 32'hDEAD_BEEF, 5'd0,  2'b00, 32'hDEAD_BEEF, 1'b0};
    vecs[5] = '{1'b1, 32'hF000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF, 1'b0};
    vecs[6] = '{1'b0, 32'h7FFF_FFFF, 5'd31, 2'b10, 32'h0000_0000, 1'b0};
    vecs[7] = '{1'b1, 32'h0000_FFFF, 5'd8,  2'b01, 32'h00FF_FF00, 1'b0};
    vecs[8] = '{1'b0, 32'hFFFF_FFFF, 5'd31, 2'b00, 32'h0000_0001, 1'b0};

    rst = 1'b1;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    set_req(1'b0, 1'b1, 32'hCAFE_0000, 5'd3, 2'b01);
    set_req(1'b1, 1'b0, 32'h0, 5'd0, 2'b00);
    exp_count = 16'd0;

    // Reset: outputs low even with a request pending.
    @(negedge clk);
    @(negedge clk);
    check("rst_req0_ready", req0_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_sh_en", sh_en, 0);
    check("rst_rsp0_valid", rsp0_valid, 0);
    check("rst_op_count", op_count, 0);
    set_req(1'b0, 1'b0, 32'h0, 5'd0, 2'b00);
    rst = 1'b0;

    // Contention straight after reset: port 0, then port 1, then port 0.
    @(negedge clk);
    set_req(1'b0, 1'b1, 32'h0000_0011, 5'd0, 2'b00);
    set_req(1'b1, 1'b1, 32'h0000_0022, 5'd0, 2'b00);
    #1;
    check("cont1_req0_ready", req0_ready, 1);
    check("cont1_req1_ready", req1_ready, 0);
    @(negedge clk);
    set_req(1'b0, 1'b1, 32'h0000_0033, 5'd1, 2'b01);
    #1;
    check("cont_issue_req0_ready", req0_ready, 0);
    check("cont_issue_req1_ready", req1_ready, 0);
    @(negedge clk);
    check("cont1_rsp0_valid", rsp0_valid, 1);
    check("cont1_rsp0_data", rsp0_data, 32'h11);
    check("cont_resp_req1_ready", req1_ready, 0);
    @(negedge clk);
    check("cont2_req1_ready", req1_ready, 1);
    check("cont2_req0_ready", req0_ready, 0);
    @(negedge clk);
    set_req(1'b1, 1'b1, 32'h0000_0044, 5'd0, 2'b00);
    @(negedge clk);
    check("cont2_rsp1_valid", rsp1_valid, 1);
    check("cont2_rsp1_data", rsp1_data, 32'h22);
    check("cont2_rsp0_valid", rsp0_valid, 0);
    @(negedge clk);
    check("cont3_req0_ready", req0_ready, 1);
    check("cont3_req1_ready", req1_ready, 0);
    @(negedge clk);
    set_req(1'b0, 1'b0, 32'h0, 5'd0, 2'b00);
    set_req(1'b1, 1'b0, 32'h0, 5'd0, 2'b00);
    @(negedge clk);
    check("cont3_rsp0_data", rsp0_data, 32'h66);
    @(negedge clk);
    exp_count = 16'd3;
    check("cont_op_count", op_count, exp_count);

    for (int i = 0; i < 9; i++) begin
      v = vecs[i];
      run_vec(v);
    end

    // Backpressure on port 0 while port 1 waits.
    rsp0_ready = 1'b0;
    @(negedge clk);
    set_req(1'b0, 1'b1, 32'hA5A5_0000, 5'd8, 2'b00);
    #1;
    check("bp_req0_ready", req0_ready, 1);
    @(negedge clk);
    set_req(1'b0, 1'b0, 32'h0, 5'd0, 2'b00);
    set_req(1'b1, 1'b1, 32'h0000_000F, 5'd4, 2'b01);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp0_valid", rsp0_valid, 1);
      check("bp_rsp0_data", rsp0_data, 32'h00A5_A500);
      check("bp_req1_ready", req1_ready, 0);
      check("bp_busy", busy, 1);
      @(negedge clk);
    end
    rsp0_ready = 1'b1;
    @(negedge clk);
    exp_count = exp_count + 16'd1;
    check("bp_op_count", op_count, exp_count);
    check("bp_req1_accept", req1_ready, 1);
    @(negedge clk);
    set_req(1'b1, 1'b0, 32'h0, 5'd0, 2'b00);
    @(negedge clk);
    check("bp_rsp1_data", rsp1_data, 32'h0000_00F0);
    @(negedge clk);
    exp_count = exp_count + 16'd1;
    check("bp_op_count2", op_count, exp_count);

    // Reset during RESP, with priority pointing at port 1 beforehand.
    v = '{1'b0, 32'h0000_0100, 5'd4, 2'b00, 32'h0000_0010, 1'b0};
    run_vec(v);
    rsp0_ready = 1'b0;
    @(negedge clk);
    set_req(1'b0, 1'b1, 32'h0000_0F00, 5'd4, 2'b00);
    @(negedge clk);
    set_req(1'b0, 1'b0, 32'h0, 5'd0, 2'b00);
    @(negedge clk);
    check("rr_pre_rsp0_valid", rsp0_valid, 1);
    rst = 1'b1;
    #1;
    check("rr_during_rsp0_valid", rsp0_valid, 0);
    check("rr_during_op_count", op_count, 0);
    @(negedge clk);
    rst = 1'b0;
    rsp0_ready = 1'b1;
    #1;
    check("rr_busy", busy, 0);
    check("rr_rsp0_valid", rsp0_valid, 0);
    check("rr_rsp0_data", rsp0_data, 0);
    check("rr_sh_en", sh_en, 0);
    check("rr_op_count", op_count, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rr_no_response", rsp0_valid | rsp1_valid, 0);
    end
    set_req(1'b0, 1'b1, 32'h0000_0001, 5'd0, 2'b00);
    set_req(1'b1, 1'b1, 32'h0000_0002, 5'd0, 2'b00);
    #1;
    check("rr_prio_req0", req0_ready, 1);
    check("rr_prio_req1", req1_ready, 0);
    @(negedge clk);
    wait_idle();
    exp_count = 16'd1;
    check("rr_op_count_after", op_count, exp_count);

    // Counter wrap: jump near the top instead of running 65536 transactions.
    @(negedge clk);
    force dut.count_q = 16'hFFFE;
    #1;
    release dut.count_q;
    exp_count = 16'hFFFE;
    v = '{1'b1, 32'h0000_0003, 5'd1, 2'b01, 32'h0000_0006, 1'b0};
    run_vec(v);
    v = '{1'b0, 32'h0000_0003, 5'd1, 2'b00, 32'h0000_0001, 1'b0};
    run_vec(v);
    check("wrap_op_count_zero", op_count, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
